// File: rtl/product_uart_tx.sv
// Queues booth_multiplier products on the tx rising edge and sends each as a UART frame.
// Define PRODUCT_TX_PARITY_EN to add an even-parity bit between data bit 7 and stop.
module product_uart_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       tx,
  input  logic [7:0] product,
  output logic       serial_out,
  output logic       busy,
  output logic       fifo_full,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef PRODUCT_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          tx_q, ovf_q;
  logic          push, push_ok, pop;

  state_t        state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    clk_q, clk_d;
  logic          last_clk;
  logic          ser;
`ifdef PRODUCT_TX_PARITY_EN
  logic          par_q, par_d;
`endif

  // tx_q resets high so a tx already asserted at reset release is ignored.
  assign push      = tx & ~tx_q;
  assign fifo_full = (count_q == CW'(FIFO_DEPTH));
  assign push_ok   = push & (~fifo_full | pop);
  assign overflow  = ovf_q;
  assign busy      = (state_q != S_IDLE) | (count_q != '0);
  assign serial_out = ser;
  assign last_clk  = (clk_q == 8'(CLKS_PER_BIT - 1));

  always_ff @(posedge CLK) begin
    if (push_ok) mem_q[wr_ptr_q] <= product;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      tx_q <= tx;
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push_ok && !pop)      count_q <= count_q + CW'(1);
      else if (!push_ok && pop) count_q <= count_q - CW'(1);
      if (push && !push_ok) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      clk_q   <= '0;
`ifdef PRODUCT_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      clk_q   <= clk_d;
`ifdef PRODUCT_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    clk_d   = clk_q;
    pop     = 1'b0;
    ser     = 1'b1;
`ifdef PRODUCT_TX_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          bit_d   = '0;
          clk_d   = '0;
          state_d = S_START;
`ifdef PRODUCT_TX_PARITY_EN
          par_d   = ^mem_q[rd_ptr_q];
`endif
        end
      end
      S_START: begin
        ser = 1'b0;
        clk_d = last_clk ? 8'd0 : clk_q + 8'd1;
        if (last_clk) state_d = S_DATA;
      end
      S_DATA: begin
        ser = shift_q[0];
        clk_d = last_clk ? 8'd0 : clk_q + 8'd1;
        if (last_clk) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef PRODUCT_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef PRODUCT_TX_PARITY_EN
      S_PARITY: begin
        ser = par_q;
        clk_d = last_clk ? 8'd0 : clk_q + 8'd1;
        if (last_clk) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        ser = 1'b1;
        clk_d = last_clk ? 8'd0 : clk_q + 8'd1;
        if (last_clk) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_product_uart_tx.sv
// Scoreboard bench: stimulus pushes expected bytes, a UART monitor decodes frames and pops/compares.
module tb_product_uart_tx;
  localparam int C     = 4;
  localparam int DEPTH = 4;
`ifdef PRODUCT_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FLEN = NB * C;

  logic       CLK = 1'b0;
  logic       RST_N, tx;
  logic [7:0] product;
  logic       serial_out, busy, fifo_full, overflow;

  int total = 0, bad = 0, frames_rx = 0;
  logic [7:0] exp_q [$];

  always #5 CLK = ~CLK;

  product_uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST_N(RST_N), .tx(tx), .product(product),
    .serial_out(serial_out), .busy(busy), .fifo_full(fifo_full), .overflow(overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: sample every cycle of a frame, demand constant bit windows, decode LSB-first.
  logic       smp [FLEN];
  logic       m_abort, m_shape;
  logic [7:0] m_byte, m_exp;
  initial begin : monitor
    forever begin
      @(negedge CLK);
      if (RST_N === 1'b1 && serial_out === 1'b0) begin
        m_abort = 1'b0;
        smp[0]  = serial_out;
        for (int i = 1; i < FLEN; i++) begin
          @(negedge CLK);
          if (RST_N !== 1'b1) begin
            m_abort = 1'b1;
            break;
          end
          smp[i] = serial_out;
        end
        if (!m_abort) begin
          m_shape = 1'b1;
          for (int b = 0; b < NB; b++)
            for (int j = 1; j < C; j++)
              if (smp[b*C+j] !== smp[b*C]) m_shape = 1'b0;
          for (int d = 0; d < 8; d++) m_byte[d] = smp[(d+1)*C];
          frames_rx++;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_frame: got %0h expected none", m_byte);
          end else begin
            m_exp = exp_q.pop_front();
            check("frame_data", {24'd0, m_byte}, {24'd0, m_exp});
            check("frame_shape_stop", {30'd0, m_shape, smp[(NB-1)*C]}, 32'd3);
`ifdef PRODUCT_TX_PARITY_EN
            check("frame_parity", {31'd0, smp[9*C]}, {31'd0, ^m_exp});
`endif
          end
        end
      end
    end
  end

  task automatic pulse(input logic [7:0] p, input bit accept);
    @(posedge CLK); #1;
    product = p;
    tx = 1'b1;
    if (accept) exp_q.push_back(p);
    @(posedge CLK); #1;
    tx = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while ((busy !== 1'b0 || exp_q.size() != 0) && n < budget) begin
      @(negedge CLK);
      n++;
    end
    check(name, {31'd0, n < budget}, 32'd1);
  endtask

  int errs, lows, highs, f0;
  logic s;

  initial begin
    RST_N = 1'b0; tx = 1'b0; product = 8'h00;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_serial", {31'd0, serial_out}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_full", {31'd0, fifo_full}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    @(posedge CLK); #1 RST_N = 1'b1;
    repeat (2) @(posedge CLK);

    // Single frame 8'h01: exact waveform and busy drop after FLEN cycles.
    pulse(8'h01, 1'b1);
    @(negedge CLK);
    check("latency_line_idle", {31'd0, serial_out}, 32'd1);
    check("latency_busy", {31'd0, busy}, 32'd1);
    errs = 0;
    for (int i = 0; i <= FLEN; i++) begin
      @(negedge CLK);
      if (i < FLEN) begin
        s = (i < C) ? 1'b0 : (i < 2*C) ? 1'b1 : (i < 9*C) ? 1'b0 : 1'b1;
        if (serial_out !== s) errs++;
        if (busy !== 1'b1) errs++;
      end else begin
        check("busy_drop", {31'd0, busy}, 32'd0);
      end
    end
    check("wave_01_errs", errs, 0);
    wait_idle(FLEN + 20, "idle_01");

    // Negative product.
    pulse(8'hFE, 1'b1);
    wait_idle(FLEN + 20, "idle_FE");

    // tx held high 100 cycles: one push only.
    f0 = frames_rx;
    @(posedge CLK); #1;
    product = 8'h31; tx = 1'b1;
    exp_q.push_back(8'h31);
    errs = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (fifo_full !== 1'b0) errs++;
    end
    check("hold_full_errs", errs, 0);
    check("hold_busy_end", {31'd0, busy}, 32'd0);
    @(posedge CLK); #1 tx = 1'b0;
    wait_idle(FLEN + 20, "idle_31");
    check("hold_frames", frames_rx - f0, 1);

    // Burst of 6 pulses: 8'h15 dropped while full.
    check("ovf_before_burst", {31'd0, overflow}, 32'd0);
    for (int k = 0; k < 6; k++) pulse(8'h10 + 8'(k), k < 5);
    @(negedge CLK);
    check("burst_full", {31'd0, fifo_full}, 32'd1);
    check("burst_ovf", {31'd0, overflow}, 32'd1);
    wait_idle(6*FLEN + 50, "idle_burst");
    check("burst_ovf_sticky", {31'd0, overflow}, 32'd1);
    check("burst_full_after", {31'd0, fifo_full}, 32'd0);

    // Reset during data bit 3 of 8'hA5 with two entries queued.
    pulse(8'hA5, 1'b1);
    pulse(8'h5A, 1'b1);
    pulse(8'h3C, 1'b1);
    repeat (14) @(posedge CLK);
    #1 RST_N = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    check("midrst_serial", {31'd0, serial_out}, 32'd1);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_ovf", {31'd0, overflow}, 32'd0);
    check("midrst_full", {31'd0, fifo_full}, 32'd0);
    exp_q.delete();
    f0 = frames_rx;
    @(posedge CLK); #1 RST_N = 1'b1;
    lows = 0; highs = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (serial_out !== 1'b1) lows++;
      if (busy !== 1'b0) highs++;
    end
    check("midrst_line_quiet", lows, 0);
    check("midrst_busy_quiet", highs, 0);
    check("midrst_frames", frames_rx - f0, 0);

    // Reset released with tx high: no capture until a fresh rise.
    @(posedge CLK); #1;
    RST_N = 1'b0; tx = 1'b1; product = 8'h44;
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;
    errs = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (busy !== 1'b0) errs++;
    end
    check("rst_tx_high_nocap", errs, 0);
    f0 = frames_rx;
    @(posedge CLK); #1 tx = 1'b0;
    pulse(8'h7E, 1'b1);
    wait_idle(FLEN + 20, "idle_7E");
    check("rst_tx_later_frames", frames_rx - f0, 1);

    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
